hazard_ctrl: RTL
================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage RV32I core. Drives stall/flush/new_pc into pc_generator, and stall/flush into the IF/ID, ID/EX and EX/MEM registers. Resolves load-use hazards, EX-stage branch/jump redirects, traps and data-memory wait states. Keeps saturating performance counters for stall cycles and flush events.

Parameters:
DRAIN_CYCLES, 2, cycles IF/ID and ID/EX stay flushed after a trap redirect (1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_uses_rs1  in  1  ID instruction reads rs1
id_uses_rs2  in  1  ID instruction reads rs2
ex_rd  in  5  rd of the instruction in EX
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch, jump or mispredict
ex_target  in  32  redirect target from EX
trap_req  in  1  trap/exception request (from MEM)
trap_vector  in  32  trap handler address
dmem_busy  in  1  data memory not ready this cycle
pc_stall  out  1  to pc_generator.stall
pc_flush  out  1  to pc_generator.flush
pc_new  out  32  to pc_generator.new_pc
if_id_stall  out  1  hold IF/ID
if_id_flush  out  1  bubble IF/ID
id_ex_flush  out  1  bubble ID/EX
ex_mem_stall  out  1  hold EX/MEM and earlier
stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1
flush_events  out  CNT_W  saturating count of cycles with pc_flush=1

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset is sampled on the rising edge and has priority over everything.
- Reset: state=RUN, pend_valid=0, pend_target=0, drain_cnt=0, counters=0. While reset=1, all control outputs and pc_new are forced to 0.
- Control outputs are combinational from registered state plus current inputs. The action takes effect at the next edge, so pc_generator shows the new_pc one edge after pc_flush=1.
- States: RUN, MEM_WAIT, DRAIN.
- Priority each cycle: trap_req > dmem_busy > pending/ex_redirect > load-use.
- trap_req=1, any state:
  - outputs: pc_flush=1, pc_new=trap_vector, if_id_flush=1, id_ex_flush=1.
  - next state DRAIN with drain_cnt=DRAIN_CYCLES; pend_valid cleared.
  - A trap while in DRAIN reloads the count.
- DRAIN: if_id_flush=1 and id_ex_flush=1 every cycle; pc advances normally. drain_cnt decrements each cycle; move to RUN after the cycle in which drain_cnt reaches 1. dmem_busy and ex_redirect are ignored in DRAIN.
- dmem_busy=1 (RUN or MEM_WAIT, no trap):
  - outputs: pc_stall=1, if_id_stall=1, ex_mem_stall=1, no flush; next state MEM_WAIT.
  - If ex_redirect=1 and pend_valid=0, capture pend_target=ex_target and set pend_valid=1. Later redirects do not overwrite.
- MEM_WAIT with dmem_busy=0:
  - If pend_valid=1: pc_flush=1, pc_new=pend_target, if_id_flush=1, id_ex_flush=1; ex_redirect is ignored this cycle; pend_valid cleared.
  - Otherwise behave as RUN.
  - Next state RUN.
- RUN, ex_redirect=1: pc_flush=1, pc_new=ex_target, if_id_flush=1, id_ex_flush=1. A redirect overrides a simultaneous load-use.
- RUN load-use:
  - Condition: ex_mem_read=1 and ex_rd!=0 and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
  - Outputs for one cycle: pc_stall=1, if_id_stall=1, id_ex_flush=1.
- pc_stall and pc_flush are never both 1. When pc_flush=0, pc_new=0.
- Counters increment on the edge after an output cycle and saturate at all-ones, with no wrap.

Test Plan:
- Reset 1 cycle, then idle inputs -> all outputs 0, stall_cycles=0, flush_events=0; pc_generator advances 0x0, 0x4, 0x8.
- ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pc_stall=1, if_id_stall=1, id_ex_flush=1; stall_cycles=1. Repeat with ex_rd=0 -> no stall.
- ex_redirect=1, ex_target=0x10000000 in RUN -> pc_flush=1, pc_new=0x10000000, both flushes; next pc_out=0x10000000, then 0x10000004; flush_events=1.
- dmem_busy=1 for 3 cycles with ex_redirect=1, ex_target=0x200 in the first busy cycle -> 3 stalled cycles with no flush. On the cycle dmem_busy falls: pc_flush=1, pc_new=0x200. stall_cycles=3.
- trap_req=1, trap_vector=0x80 during MEM_WAIT with a pending redirect -> pc_new=0x80 and the pending redirect is discarded. if_id_flush and id_ex_flush are high for 1+DRAIN_CYCLES=3 cycles, then RUN.
- reset asserted in MEM_WAIT with pend_valid=1 -> next cycle RUN, no flush, counters 0. Counter preload to all-ones plus a stall -> the counter holds at all-ones.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stalls, EX redirects, traps with a drain
// window, and data-memory wait states with a deferred redirect.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_target,
  input  logic             trap_req,
  input  logic [31:0]      trap_vector,
  input  logic             dmem_busy,
  output logic             pc_stall,
  output logic             pc_flush,
  output logic [31:0]      pc_new,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DRAIN    = 2'd2;

  logic [1:0]  state;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [3:0]  drain_cnt;
  logic        load_use;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Priority chain: trap, drain window, memory wait, deferred/live redirect, load-use.
  always_comb begin
    pc_stall     = 1'b0;
    pc_flush     = 1'b0;
    pc_new       = 32'd0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    if (reset) begin
      pc_stall = 1'b0;
    end else if (trap_req) begin
      pc_flush    = 1'b1;
      pc_new      = trap_vector;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (state == DRAIN) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if ((state == MEM_WAIT) && pend_valid) begin
      pc_flush    = 1'b1;
      pc_new      = pend_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (ex_redirect) begin
      pc_flush    = 1'b1;
      pc_new      = ex_target;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      pend_valid   <= 1'b0;
      pend_target  <= 32'd0;
      drain_cnt    <= 4'd0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (pc_flush && (flush_events != '1))
        flush_events <= flush_events + CNT_W'(1);

      if (trap_req) begin
        state      <= DRAIN;
        drain_cnt  <= 4'(DRAIN_CYCLES);
        pend_valid <= 1'b0;
      end else if (state == DRAIN) begin
        if (drain_cnt <= 4'd1) begin
          state     <= RUN;
          drain_cnt <= 4'd0;
        end else begin
          drain_cnt <= drain_cnt - 4'd1;
        end
      end else if (dmem_busy) begin
        state <= MEM_WAIT;
        // Only the first redirect seen during a wait is kept.
        if (ex_redirect && !pend_valid) begin
          pend_valid  <= 1'b1;
          pend_target <= ex_target;
        end
      end else begin
        state      <= RUN;
        pend_valid <= 1'b0;
      end
    end
  end

endmodule
